sar_search: RTL and testbench



---
 rtl/sar_pkg.sv | 13 +
 rtl/sar_search_if.sv | 29 ++
 rtl/comparator_4bit_struct.sv | 19 +
 rtl/sar_search.sv | 117 +++++++++++
 tb/tb_sar_search.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search and its comparator.
package sar_pkg;

  // Default trial/result width, shared with the comparator wrapper.
  localparam int SAR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } sar_state_e;

endpackage

// File: rtl/sar_search_if.sv
// Request/result handshake plus the comparator question/answer pair.
// The master side issues start and supplies the relation flags.
// The slave side (sar_search) drives the trial value and reports the outcome.
interface sar_search_if
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
);
  logic             start;
  logic             a_maior_que_b;
  logic             a_menor_que_b;
  logic             a_igual_b;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             exact;
  logic             err;

  modport master (
    output start, a_maior_que_b, a_menor_que_b, a_igual_b,
    input  trial, busy, done, result, exact, err
  );

  modport slave (
    input  start, a_maior_que_b, a_menor_que_b, a_igual_b,
    output trial, busy, done, result, exact, err
  );
endinterface

// File: rtl/comparator_4bit_struct.sv
// Combinational magnitude comparator: relation of a to b as three flags.
module comparator_4bit_struct
  import sar_pkg::*;
(
  input  logic [SAR_WIDTH-1:0] a,
  input  logic [SAR_WIDTH-1:0] b,
  output logic                 a_maior_que_b,
  output logic                 a_menor_que_b,
  output logic                 a_igual_b
);

  // Exactly one flag is high for any pair of inputs.
  always_comb begin
    a_maior_que_b = (a > b);
    a_menor_que_b = (a < b);
    a_igual_b     = (a == b);
  end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation controller: binary-searches the comparator's
// unknown 'a' input by driving trial values onto its 'b' input.
//
// state  | meaning
// IDLE   | waiting for start; result/exact/err hold the last outcome
// SEARCH | one bit resolved per cycle from the comparator flags
// DONE   | one-cycle done pulse, trial parked at zero
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  sar_search_if.slave bus
);

  localparam int             IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]  IDX_TOP = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_BIT = WIDTH'(1) << (WIDTH - 1);

  sar_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exact_q, exact_d;
  logic             err_q, err_d;

  logic [2:0]       flags;
  logic             flags_one_hot;
  logic [WIDTH-1:0] idx_bit;
  logic [WIDTH-1:0] adj_trial;

  assign flags         = {bus.a_maior_que_b, bus.a_menor_que_b, bus.a_igual_b};
  assign flags_one_hot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);

  // Next-state and datapath: bit set/clear only, idx walks MSB to LSB.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    trial_d   = trial_q;
    result_d  = result_q;
    exact_d   = exact_q;
    err_d     = err_q;
    idx_bit   = WIDTH'(1) << idx_q;
    // Only consulted once the flags are known one-hot, so !gt means lt.
    adj_trial = bus.a_maior_que_b ? trial_q : (trial_q & ~idx_bit);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SEARCH;
          idx_d    = IDX_TOP;
          trial_d  = MSB_BIT;
          result_d = '0;
          exact_d  = 1'b0;
          err_d    = 1'b0;
        end
      end
      SEARCH: begin
        if (!flags_one_hot) begin
          err_d    = 1'b1;
          result_d = '0;
          trial_d  = '0;
          state_d  = DONE;
        end else if (bus.a_igual_b) begin
          result_d = trial_q;
          exact_d  = 1'b1;
          trial_d  = '0;
          state_d  = DONE;
        end else if (idx_q == '0) begin
          result_d = adj_trial;
          trial_d  = '0;
          state_d  = DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          trial_d = adj_trial | (idx_bit >> 1);
        end
      end
      DONE: begin
        trial_d = '0;
        state_d = IDLE;
      end
      default: begin
        trial_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any search without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      trial_q  <= '0;
      result_q <= '0;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      exact_q  <= exact_d;
      err_q    <= err_d;
    end
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = (state_q == SEARCH);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.exact  = exact_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;
  import sar_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] a_val;
  logic       force_en;
  logic [2:0] force_flags;
  logic       cmp_gt, cmp_lt, cmp_eq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] obs_trials [8];
  int         obs_n;
  int         obs_done_cyc;

  sar_search_if #(.WIDTH(4)) bus ();

  sar_search #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  comparator_4bit_struct cmp (
    .a             (a_val),
    .b             (bus.trial),
    .a_maior_que_b (cmp_gt),
    .a_menor_que_b (cmp_lt),
    .a_igual_b     (cmp_eq)
  );

  assign bus.a_maior_que_b = force_en ? force_flags[2] : cmp_gt;
  assign bus.a_menor_que_b = force_en ? force_flags[1] : cmp_lt;
  assign bus.a_igual_b     = force_en ? force_flags[0] : cmp_eq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start, then record trials while busy until done (cycle 1 = first SEARCH cycle).
  task automatic do_search(input logic [3:0] a);
    a_val = a;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    obs_n = 0;
    obs_done_cyc = -1;
    for (int i = 0; i < 8; i++) obs_trials[i] = 4'hx;
    for (int c = 1; c <= 20; c++) begin
      if (bus.done) begin
        obs_done_cyc = c;
        break;
      end
      if (bus.busy && obs_n < 8) begin
        obs_trials[obs_n] = bus.trial;
        obs_n++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.start = 1'b0;
    #1 rst_n = 1'b0;
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.trial, bus.busy, bus.done, bus.result, bus.exact, bus.err} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs got trial=%0d busy=%0b done=%0b result=%0d exact=%0b err=%0b exp all 0",
               bus.trial, bus.busy, bus.done, bus.result, bus.exact, bus.err);
    end
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_after_release got busy=%0b exp 0", bus.busy);
    end
  endtask

  task automatic test_a11();
    logic [3:0] exp_t [4] = '{4'd8, 4'd12, 4'd10, 4'd11};
    do_search(4'b1011);
    n_checks++;
    if (obs_n !== 4) begin
      n_fail++;
      $display("FAIL a11_trial_count got=%0d exp=4", obs_n);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_trials[i] !== exp_t[i]) begin
        n_fail++;
        $display("FAIL a11_trial%0d got=%0d exp=%0d", i, obs_trials[i], exp_t[i]);
      end
    end
    n_checks++;
    if (obs_done_cyc !== 5) begin
      n_fail++;
      $display("FAIL a11_done_cycle got=%0d exp=5", obs_done_cyc);
    end
    n_checks++;
    if (bus.result !== 4'd11 || bus.exact !== 1'b1 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL a11_result got result=%0d exact=%0b err=%0b exp 11/1/0", bus.result, bus.exact, bus.err);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.trial !== 4'd0) begin
      n_fail++;
      $display("FAIL a11_done_state got busy=%0b trial=%0d exp 0/0", bus.busy, bus.trial);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.result !== 4'd11) begin
      n_fail++;
      $display("FAIL a11_done_one_cycle got done=%0b result=%0d exp 0/11", bus.done, bus.result);
    end
  endtask

  task automatic test_a0();
    logic [3:0] exp_t [4] = '{4'd8, 4'd4, 4'd2, 4'd1};
    do_search(4'd0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_trials[i] !== exp_t[i]) begin
        n_fail++;
        $display("FAIL a0_trial%0d got=%0d exp=%0d", i, obs_trials[i], exp_t[i]);
      end
    end
    n_checks++;
    if (obs_done_cyc !== 5 || bus.result !== 4'd0 || bus.exact !== 1'b0) begin
      n_fail++;
      $display("FAIL a0_result got cyc=%0d result=%0d exact=%0b exp 5/0/0", obs_done_cyc, bus.result, bus.exact);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_a8();
    do_search(4'd8);
    n_checks++;
    if (obs_n !== 1 || obs_trials[0] !== 4'd8) begin
      n_fail++;
      $display("FAIL a8_trials got n=%0d t0=%0d exp 1/8", obs_n, obs_trials[0]);
    end
    n_checks++;
    if (obs_done_cyc !== 2 || bus.result !== 4'd8 || bus.exact !== 1'b1) begin
      n_fail++;
      $display("FAIL a8_result got cyc=%0d result=%0d exact=%0b exp 2/8/1", obs_done_cyc, bus.result, bus.exact);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_err();
    force_en = 1'b1;
    force_flags = 3'b000;
    do_search(4'd5);
    n_checks++;
    if (obs_done_cyc !== 2 || bus.err !== 1'b1 || bus.result !== 4'd0 || bus.exact !== 1'b0) begin
      n_fail++;
      $display("FAIL err_flagged got cyc=%0d err=%0b result=%0d exact=%0b exp 2/1/0/0",
               obs_done_cyc, bus.err, bus.result, bus.exact);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got=%0b exp=1", bus.err);
    end
    force_en = 1'b0;
    do_search(4'd13);
    n_checks++;
    if (bus.err !== 1'b0 || bus.result !== 4'd13 || bus.exact !== 1'b1) begin
      n_fail++;
      $display("FAIL err_cleared got err=%0b result=%0d exact=%0b exp 0/13/1", bus.err, bus.result, bus.exact);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    logic [3:0] exp_t [4] = '{4'd8, 4'd12, 4'd10, 4'd11};
    int n;
    int done_cyc;
    logic [3:0] tr [4];
    a_val = 4'd11;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    done_cyc = -1;
    for (int i = 0; i < 4; i++) tr[i] = 4'hx;
    for (int c = 1; c <= 20; c++) begin
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      if (n < 4) begin
        tr[n] = bus.trial;
        n++;
      end
      bus.start = (c == 2 || c == 3);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tr[i] !== exp_t[i]) begin
        n_fail++;
        $display("FAIL ign_trial%0d got=%0d exp=%0d", i, tr[i], exp_t[i]);
      end
    end
    n_checks++;
    if (done_cyc !== 5 || bus.result !== 4'd11 || bus.exact !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_result got cyc=%0d result=%0d exact=%0b exp 5/11/1", done_cyc, bus.result, bus.exact);
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 4'd11 || bus.exact !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_done_start got busy=%0b done=%0b result=%0d exact=%0b exp 0/0/11/1",
               bus.busy, bus.done, bus.result, bus.exact);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_stays_idle got busy=%0b exp 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_t [4] = '{4'd8, 4'd4, 4'd6, 4'd7};
    do_search(4'd8);
    @(posedge clk); #1;
    do_search(4'd7);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_trials[i] !== exp_t[i]) begin
        n_fail++;
        $display("FAIL b2b_trial%0d got=%0d exp=%0d", i, obs_trials[i], exp_t[i]);
      end
    end
    n_checks++;
    if (obs_done_cyc !== 5 || bus.result !== 4'd7 || bus.exact !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_result got cyc=%0d result=%0d exact=%0b exp 5/7/1", obs_done_cyc, bus.result, bus.exact);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_search();
    logic [3:0] exp_t [4] = '{4'd8, 4'd12, 4'd14, 4'd15};
    a_val = 4'd9;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.trial !== 4'd12) begin
      n_fail++;
      $display("FAIL rst_mid_pre got busy=%0b trial=%0d exp 1/12", bus.busy, bus.trial);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.trial, bus.busy, bus.done, bus.result, bus.exact, bus.err} !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got trial=%0d busy=%0b done=%0b result=%0d exact=%0b err=%0b exp all 0",
               bus.trial, bus.busy, bus.done, bus.result, bus.exact, bus.err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_no_pulse got done=%0b busy=%0b exp 0/0", bus.done, bus.busy);
    end
    do_search(4'd15);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_trials[i] !== exp_t[i]) begin
        n_fail++;
        $display("FAIL rst_a15_trial%0d got=%0d exp=%0d", i, obs_trials[i], exp_t[i]);
      end
    end
    n_checks++;
    if (obs_done_cyc !== 5 || bus.result !== 4'd15 || bus.exact !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_a15_result got cyc=%0d result=%0d exact=%0b exp 5/15/1", obs_done_cyc, bus.result, bus.exact);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    a_val = 4'd0;
    force_en = 1'b0;
    force_flags = 3'b000;
    bus.start = 1'b0;
    test_reset();
    test_a11();
    test_a0();
    test_a8();
    test_err();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_search();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
